register_file: RTL

//  Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer (ROB).

---
 rtl/register_file_pkg.sv | 18 +
 rtl/register_file_operand_resolve.sv | 38 +++
 rtl/register_file.sv | 122 ++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and helpers for the architectural register file and its operand resolver.
package register_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_WIDTH = 5;
  localparam int REG_NUM   = 2 ** REG_WIDTH;
  localparam int ROB_WIDTH = 4;

  localparam logic [REG_WIDTH-1:0] REG_ZERO  = {REG_WIDTH{1'b0}};
  localparam logic [ROB_WIDTH-1:0] TAG_ZERO  = {ROB_WIDTH{1'b0}};
  localparam logic [XLEN-1:0]      DATA_ZERO = {XLEN{1'b0}};

  // x0 is hardwired to zero, so it is never a legal write target.
  function automatic logic reg_writable(input logic [REG_WIDTH-1:0] idx);
    return (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/register_file_operand_resolve.sv
// Zero-cycle operand resolution: picks a value or a pending producer tag for one source.
module register_file_operand_resolve
  import register_file_pkg::*;
(
  input  logic [REG_WIDTH-1:0] idx_i,
  input  logic                 busy_i,
  input  logic [ROB_WIDTH-1:0] tag_i,
  input  logic [XLEN-1:0]      data_i,
  input  logic [REG_WIDTH-1:0] commit_reg_id_i,
  input  logic [ROB_WIDTH-1:0] commit_rob_id_i,
  input  logic [XLEN-1:0]      commit_data_i,
  input  logic                 rob_ready_i,
  input  logic [XLEN-1:0]      rob_data_i,
  output logic [XLEN-1:0]      val_o,
  output logic                 dep_o,
  output logic [ROB_WIDTH-1:0] rob_id_o
);

  // Priority mux: x0, idle register, commit bypass, ROB forward, else still pending.
  always_comb begin
    val_o    = DATA_ZERO;
    dep_o    = 1'b0;
    rob_id_o = TAG_ZERO;
    if (idx_i == REG_ZERO) begin
      val_o = DATA_ZERO;
    end else if (!busy_i) begin
      val_o = data_i;
    end else if ((commit_reg_id_i == idx_i) && (commit_rob_id_i == tag_i)) begin
      val_o = commit_data_i;
    end else if (rob_ready_i) begin
      val_o = rob_data_i;
    end else begin
      dep_o    = 1'b1;
      rob_id_o = tag_i;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, fed by ROB commits and decoder issue.
module register_file
  import register_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 dec_rdy,
  input  logic [REG_WIDTH-1:0] dec_dest,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [REG_WIDTH-1:0] dec_rs1,
  input  logic [REG_WIDTH-1:0] dec_rs2,
  output logic [XLEN-1:0]      src1_val,
  output logic                 src1_dep,
  output logic [ROB_WIDTH-1:0] src1_rob_id,
  output logic [XLEN-1:0]      src2_val,
  output logic                 src2_dep,
  output logic [ROB_WIDTH-1:0] src2_rob_id,
  output logic [ROB_WIDTH-1:0] reg_rob_id_j,
  input  logic                 reg_ready_j,
  input  logic [XLEN-1:0]      reg_data_j,
  output logic [ROB_WIDTH-1:0] reg_rob_id_k,
  input  logic                 reg_ready_k,
  input  logic [XLEN-1:0]      reg_data_k,
  input  logic [REG_WIDTH-1:0] commit_reg_id,
  input  logic [XLEN-1:0]      commit_data,
  input  logic [ROB_WIDTH-1:0] commit_rob_id
);

  logic [XLEN-1:0]      data_q [REG_NUM];
  logic [XLEN-1:0]      data_d [REG_NUM];
  logic                 busy_q [REG_NUM];
  logic                 busy_d [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_d  [REG_NUM];

  logic commit_en_s;
  logic issue_en_s;

  assign commit_en_s = rdy_in && reg_writable(commit_reg_id);
  assign issue_en_s  = rdy_in && dec_rdy && !flush && reg_writable(dec_dest);

  // Next-state: commit writes data first, then flush or issue override busy/tag.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_en_s) begin
      data_d[commit_reg_id] = commit_data;
      // A stale commit (older producer) must not release a renamed register.
      if (tag_q[commit_reg_id] == commit_rob_id) begin
        busy_d[commit_reg_id] = 1'b0;
      end else begin
        busy_d[commit_reg_id] = busy_q[commit_reg_id];
      end
    end else begin
      data_d = data_q;
    end
    if (rdy_in && flush) begin
      for (int i = 0; i < REG_NUM; i++) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = TAG_ZERO;
      end
    end else if (issue_en_s) begin
      // Issue is applied last so it wins over a same-register commit.
      busy_d[dec_dest] = 1'b1;
      tag_d[dec_dest]  = dec_rob_id;
    end else begin
      tag_d = tag_q;
    end
  end

  // State registers with immediate clear on asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= DATA_ZERO;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= TAG_ZERO;
      end
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign reg_rob_id_j = tag_q[dec_rs1];
  assign reg_rob_id_k = tag_q[dec_rs2];

  register_file_operand_resolve u_resolve_j (
    .idx_i           (dec_rs1),
    .busy_i          (busy_q[dec_rs1]),
    .tag_i           (tag_q[dec_rs1]),
    .data_i          (data_q[dec_rs1]),
    .commit_reg_id_i (commit_reg_id),
    .commit_rob_id_i (commit_rob_id),
    .commit_data_i   (commit_data),
    .rob_ready_i     (reg_ready_j),
    .rob_data_i      (reg_data_j),
    .val_o           (src1_val),
    .dep_o           (src1_dep),
    .rob_id_o        (src1_rob_id)
  );

  register_file_operand_resolve u_resolve_k (
    .idx_i           (dec_rs2),
    .busy_i          (busy_q[dec_rs2]),
    .tag_i           (tag_q[dec_rs2]),
    .data_i          (data_q[dec_rs2]),
    .commit_reg_id_i (commit_reg_id),
    .commit_rob_id_i (commit_rob_id),
    .commit_data_i   (commit_data),
    .rob_ready_i     (reg_ready_k),
    .rob_data_i      (reg_data_k),
    .val_o           (src2_val),
    .dep_o           (src2_dep),
    .rob_id_o        (src2_rob_id)
  );

endmodule
